// File: rtl/block_transfer_sequencer_pkg.sv
// Shared constants, state encoding and helpers for the block transfer sequencer.
package block_transfer_sequencer_pkg;

  localparam int unsigned NumRegs   = 15;
  localparam int unsigned RegAddrW  = 4;
  localparam int unsigned WordBytes = 4;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } state_e;

  function automatic logic [RegAddrW-1:0] popcount(input logic [NumRegs-1:0] mask);
    logic [RegAddrW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NumRegs; i++) begin
      cnt = cnt + RegAddrW'(mask[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/block_transfer_sequencer_lowest_set_bit_encoder.sv
// Combinational priority encoder: index of the lowest set bit of a register mask.
module lowest_set_bit_encoder
  import block_transfer_sequencer_pkg::*;
(
  input  logic [NumRegs-1:0]  i_mask,
  output logic [RegAddrW-1:0] o_idx,
  output logic                o_zero
);

  // Scan downwards so the lowest set bit is the last assignment to win.
  always_comb begin
    o_idx = '0;
    for (int i = NumRegs - 1; i >= 0; i--) begin
      if (i_mask[i]) o_idx = RegAddrW'(i);
    end
  end

  assign o_zero = (i_mask == '0);

endmodule

// File: rtl/block_transfer_sequencer.sv
// Load/store-multiple sequencer: walks a register list in ascending order, one access per register.
module block_transfer_sequencer
  import block_transfer_sequencer_pkg::*;
#(
  parameter int unsigned WordLen = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                isLoad,
  input  logic [NumRegs-1:0]  regList,
  input  logic [WordLen-1:0]  baseAddr,
  output logic                busy,
  output logic                done,
  output logic [RegAddrW-1:0] rfReadAddr,
  input  logic [WordLen-1:0]  rfReadData,
  output logic [RegAddrW-1:0] rfWriteAddr,
  output logic [WordLen-1:0]  rfWriteData,
  output logic                rfWriteEn,
  output logic [WordLen-1:0]  memAddr,
  output logic [WordLen-1:0]  memWriteData,
  output logic                memReadEn,
  output logic                memWriteEn,
  input  logic [WordLen-1:0]  memReadData,
  input  logic                memReady,
  output logic [WordLen-1:0]  wbAddr
);

  state_e               r_state;
  logic [NumRegs-1:0]   r_mask;
  logic [WordLen-1:0]   r_cur_addr;
  logic                 r_load;
  logic [WordLen-1:0]   r_wb_addr;
  logic                 r_rf_we;
  logic [RegAddrW-1:0]  r_rf_waddr;
  logic [WordLen-1:0]   r_rf_wdata;

  logic [RegAddrW-1:0]  w_idx;
  logic                 w_zero;
  logic                 w_access;
  logic [NumRegs-1:0]   w_mask_next;

  lowest_set_bit_encoder u_lsb (
    .i_mask (r_mask),
    .o_idx  (w_idx),
    .o_zero (w_zero)
  );

  assign w_access    = (r_state == StAccess) && !w_zero;
  assign w_mask_next = r_mask & ~(NumRegs'(1) << w_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_mask     <= '0;
      r_cur_addr <= '0;
      r_load     <= 1'b0;
      r_wb_addr  <= '0;
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else begin
      r_rf_we <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_mask     <= regList;
            r_cur_addr <= baseAddr;
            r_load     <= isLoad;
            r_wb_addr  <= baseAddr + (WordLen'(popcount(regList)) * WordLen'(WordBytes));
            r_state    <= (regList == '0) ? StDone : StAccess;
          end
        end
        StAccess: begin
          if (memReady) begin
            r_mask     <= w_mask_next;
            r_cur_addr <= r_cur_addr + WordLen'(WordBytes);
            // Load data lands in the register file during the following cycle.
            if (r_load) begin
              r_rf_we    <= 1'b1;
              r_rf_waddr <= w_idx;
              r_rf_wdata <= memReadData;
            end
            if (w_mask_next == '0) r_state <= StDone;
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy         = (r_state == StAccess);
  assign done         = (r_state == StDone);
  assign memReadEn    = w_access && r_load;
  assign memWriteEn   = w_access && !r_load;
  assign memAddr      = w_access ? r_cur_addr : '0;
  assign rfReadAddr   = w_access ? w_idx : '0;
  assign memWriteData = w_access ? rfReadData : '0;
  assign rfWriteEn    = r_rf_we;
  assign rfWriteAddr  = r_rf_waddr;
  assign rfWriteData  = r_rf_wdata;
  assign wbAddr       = r_wb_addr;

endmodule

// File: tb/tb_block_transfer_sequencer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_block_transfer_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, isLoad, memReady;
  logic [14:0] regList;
  logic [31:0] baseAddr, memReadData, rfReadData;
  logic        busy, done, rfWriteEn, memReadEn, memWriteEn;
  logic [3:0]  rfReadAddr, rfWriteAddr;
  logic [31:0] rfWriteData, memAddr, memWriteData, wbAddr;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 0;

  logic [31:0] rf   [16];
  logic [31:0] rf_m [16];

  block_transfer_sequencer #(.WordLen(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .isLoad       (isLoad),
    .regList      (regList),
    .baseAddr     (baseAddr),
    .busy         (busy),
    .done         (done),
    .rfReadAddr   (rfReadAddr),
    .rfReadData   (rfReadData),
    .rfWriteAddr  (rfWriteAddr),
    .rfWriteData  (rfWriteData),
    .rfWriteEn    (rfWriteEn),
    .memAddr      (memAddr),
    .memWriteData (memWriteData),
    .memReadEn    (memReadEn),
    .memWriteEn   (memWriteEn),
    .memReadData  (memReadData),
    .memReady     (memReady),
    .wbAddr       (wbAddr)
  );

  always #5 clk = ~clk;

  // Register file: combinational read, negedge write.
  assign rfReadData = rf[rfReadAddr];
  always @(negedge clk) if (rfWriteEn) rf[rfWriteAddr] <= rfWriteData;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  bit          m_busy = 0, m_done = 0, m_load = 0, m_we = 0, nw;
  logic [31:0] m_wb = 0, m_wd = 0, a;
  logic [3:0]  m_wa = 0;
  int          q_idx[$];
  logic [31:0] q_addr[$];

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_wb = 0; m_we = 0;
      q_idx.delete(); q_addr.delete();
    end else begin
      nw = 0;
      if (m_busy) begin
        if (memReady) begin
          if (m_load) begin
            nw = 1; m_wa = 4'(q_idx[0]); m_wd = memReadData;
            rf_m[q_idx[0]] = memReadData;
          end
          void'(q_idx.pop_front());
          void'(q_addr.pop_front());
          if (q_idx.size() == 0) begin m_busy = 0; m_done = 1; end
        end
      end else if (m_done) begin
        m_done = 0;
      end else if (start) begin
        a = baseAddr;
        for (int i = 0; i < 15; i++) begin
          if (regList[i]) begin
            q_idx.push_back(i); q_addr.push_back(a); a = a + 32'd4;
          end
        end
        m_load = isLoad;
        m_wb   = baseAddr + 32'(4 * q_idx.size());
        if (q_idx.size() == 0) m_done = 1; else m_busy = 1;
      end
      m_we = nw;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("memReadEn", memReadEn, m_busy && m_load);
      chk("memWriteEn", memWriteEn, m_busy && !m_load);
      chk("rfWriteEn", rfWriteEn, m_we);
      if (m_we) begin
        chk("rfWriteAddr", rfWriteAddr, m_wa);
        chk("rfWriteData", rfWriteData, m_wd);
      end
      if (m_busy) begin
        chk("memAddr", memAddr, q_addr[0]);
        chk("rfReadAddr", rfReadAddr, q_idx[0]);
        if (!m_load) chk("memWriteData", memWriteData, rf_m[q_idx[0]]);
      end
      if (m_done) chk("wbAddr", wbAddr, m_wb);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int n_done;

  initial begin
    for (int i = 0; i < 16; i++) begin rf[i] = $urandom; rf_m[i] = rf[i]; end
    rst = 1; start = 0; isLoad = 0; regList = '0; baseAddr = '0;
    memReady = 0; memReadData = '0;
    tick(); tick();
    chk_en = 1;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_wbAddr", wbAddr, 0);
    tick();
    rst = 0;
    tick();

    // Store R0,R2 at 0x100.
    start = 1; isLoad = 0; regList = 15'h0005; baseAddr = 32'h100; memReady = 1;
    tick(); start = 0;
    @(negedge clk);
    chk("st_wen1", memWriteEn, 1); chk("st_addr1", memAddr, 32'h100); chk("st_ra1", rfReadAddr, 0);
    tick(); @(negedge clk);
    chk("st_addr2", memAddr, 32'h104); chk("st_ra2", rfReadAddr, 2);
    tick(); @(negedge clk);
    chk("st_done", done, 1); chk("st_wb", wbAddr, 32'h108); chk("st_busy", busy, 0);
    tick(); @(negedge clk);
    chk("st_done_once", done, 0);
    tick();

    // Load R0,R14 at 0x200.
    start = 1; isLoad = 1; regList = 15'h4001; baseAddr = 32'h200; memReadData = 32'hAA;
    tick(); start = 0;
    @(negedge clk);
    chk("ld_ren", memReadEn, 1); chk("ld_addr1", memAddr, 32'h200);
    tick(); memReadData = 32'hBB;
    @(negedge clk);
    chk("ld_we1", rfWriteEn, 1); chk("ld_wa1", rfWriteAddr, 0); chk("ld_wd1", rfWriteData, 32'hAA);
    chk("ld_addr2", memAddr, 32'h204);
    tick(); @(negedge clk);
    chk("ld_done", done, 1); chk("ld_we2", rfWriteEn, 1);
    chk("ld_wa2", rfWriteAddr, 14); chk("ld_wd2", rfWriteData, 32'hBB);
    tick();
    chk("ld_rb0", rf[0], 32'hAA); chk("ld_rb14", rf[14], 32'hBB);

    // Stalled load of R3.
    start = 1; isLoad = 1; regList = 15'h0008; baseAddr = 32'h300; memReady = 0;
    tick(); start = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_ren", memReadEn, 1); chk("stall_addr", memAddr, 32'h300); chk("stall_we", rfWriteEn, 0);
      tick();
    end
    memReady = 1; memReadData = 32'h1234;
    tick(); @(negedge clk);
    chk("stall_we_after", rfWriteEn, 1); chk("stall_wa", rfWriteAddr, 3);
    chk("stall_wd", rfWriteData, 32'h1234); chk("stall_done", done, 1);
    tick();

    // Empty list.
    start = 1; isLoad = 1; regList = '0; baseAddr = 32'h40;
    tick(); start = 0;
    @(negedge clk);
    chk("empty_done", done, 1); chk("empty_wb", wbAddr, 32'h40);
    chk("empty_ren", memReadEn, 0); chk("empty_wen", memWriteEn, 0); chk("empty_we", rfWriteEn, 0);
    tick(); tick();

    // Reset during the second access of a 4-register load.
    start = 1; isLoad = 1; regList = 15'h000F; baseAddr = 32'h500; memReady = 1; memReadData = $urandom;
    tick(); start = 0;
    tick(); rst = 1;
    tick(); rst = 0;
    @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_we", rfWriteEn, 0);
    chk("rst_ren", memReadEn, 0); chk("rst_maddr", memAddr, 0); chk("rst_wb", wbAddr, 0);
    tick();

    // start held (and regList changed) while busy: exactly one transfer.
    start = 1; isLoad = 1; regList = 15'h00F0; baseAddr = 32'h600; memReady = 1;
    n_done = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 1) regList = 15'h7FFF;
      memReadData = $urandom;
      @(negedge clk);
      if (done) n_done++;
    end
    start = 0;
    for (int k = 0; k < 3; k++) begin
      tick(); @(negedge clk);
      if (done) n_done++;
    end
    chk("busy_start_dones", 32'(n_done), 1);
    chk("busy_start_idle", busy, 0);
    tick();

    // Address wrap-around store.
    start = 1; isLoad = 0; regList = 15'h0006; baseAddr = 32'hFFFF_FFFC;
    tick(); start = 0;
    @(negedge clk);
    chk("wrap_addr1", memAddr, 32'hFFFF_FFFC); chk("wrap_ra1", rfReadAddr, 1);
    tick(); @(negedge clk);
    chk("wrap_addr2", memAddr, 32'h0); chk("wrap_ra2", rfReadAddr, 2);
    tick(); @(negedge clk);
    chk("wrap_wb", wbAddr, 32'h4);
    tick();

    // Randomized traffic.
    for (int c = 0; c < 2000; c++) begin
      rst         = ($urandom % 64) == 0;
      start       = ($urandom % 4) == 0;
      isLoad      = $urandom % 2;
      regList     = (($urandom % 8) == 0) ? 15'h0 : 15'($urandom);
      baseAddr    = $urandom;
      memReady    = ($urandom % 4) != 0;
      memReadData = $urandom;
      tick();
    end
    rst = 0; start = 0; memReady = 1;
    begin
      int budget = 40;
      while ((busy || done) && budget > 0) begin tick(); budget--; end
      chk("drain_timeout", 32'(budget > 0), 1);
    end
    tick(); tick();
    for (int i = 0; i < 15; i++) chk("rf_readback", rf[i], rf_m[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/block_transfer_sequencer.md
Name: block_transfer_sequencer

Overview:
- Multi-cycle load-multiple/store-multiple sequencer: the initiator side of the 15-entry register file.
- Walks a register list in ascending order, issuing one memory access per selected register.
- Load: drives register-file writes. Store: drives register-file reads.
- Sits beside the EXE/MEM stage; the pipeline stalls on busy.

Parameters:
WordLen, 32, data/address width
NumRegs, 15, register-file entries addressed (R0..R14); list width and scan range

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  begin transfer; sampled only in IDLE
isLoad  in  1  1 = load-multiple (memory to regs), 0 = store-multiple (regs to memory)
regList  in  NumRegs  bit i selects Ri
baseAddr  in  WordLen  start address, increment-after addressing
busy  out  1  transfer in progress
done  out  1  one-cycle completion pulse
rfReadAddr  out  4  register-file read port select
rfReadData  in  WordLen  combinational read data from register file
rfWriteAddr  out  4  register-file write select
rfWriteData  out  WordLen  register-file write data
rfWriteEn  out  1  register-file write enable
memAddr  out  WordLen  access address
memWriteData  out  WordLen  store data (= rfReadData)
memReadEn  out  1  load request
memWriteEn  out  1  store request
memReadData  in  WordLen  load data, valid with memReady
memReady  in  1  access accepted/completed this cycle
wbAddr  out  WordLen  baseAddr + 4*popcount(regList); valid while done=1

Behaviour:
- Reset (synchronous, rst high at posedge clk):
  - State goes to IDLE.
  - All outputs are 0 and the pending mask is cleared.
  - Any in-flight access is abandoned and no rfWriteEn is issued.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - busy=0, all requests 0.
  - If start=1 at posedge, latch pendingMask=regList, curAddr=baseAddr, loadFlag=isLoad, and wbAddr=baseAddr+4*popcount(regList).
  - Next state is ACCESS if regList!=0, else DONE (an empty list makes no access).
- ACCESS:
  - busy=1; curIdx = lowest set bit of pendingMask.
  - memAddr=curAddr.
  - memReadEn=loadFlag; memWriteEn=!loadFlag.
  - rfReadAddr=curIdx; memWriteData=rfReadData (combinational).
  - Request is held stable until memReady=1.
  - On a posedge with memReady=1: clear bit curIdx and set curAddr+=4 (wraps modulo 2^WordLen).
  - For a load, also register memReadData/curIdx into rfWriteData/rfWriteAddr and assert rfWriteEn for exactly the next cycle.
  - After a handshake, the next request appears the following cycle, so holding memReady high gives one transfer per cycle.
  - When the mask becomes 0, the next state is DONE.
- Register-file write timing: the register file writes on negedge, so a registered rfWriteEn held for the full cycle lands mid-cycle.
- DONE:
  - Lasts one cycle: done=1, busy=0, no requests.
  - For a load, the final rfWriteEn occurs in this cycle.
  - Next state is IDLE; a start arriving in DONE is ignored.
- start while busy or in DONE: ignored; no queueing.
- memReady is ignored when no request is asserted.
- Register order is always ascending index regardless of address; no decrement modes.
- rfWriteEn is never asserted in IDLE, and never for a store.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE/ACCESS/DONE);
  - NumRegs=15 and the register-address width of 4;
  - the word-size byte increment of 4.
- Sub-module lowest_set_bit_encoder: combinational, NumRegs-bit mask in, 4-bit index out plus a zero flag. It is reused for the popcount-free scan.

Test Plan:
- Store, regList=15'h0005, base=0x100, memReady always 1.
  - Cycle 1: memWriteEn=1, addr 0x100, rfReadAddr=0.
  - Cycle 2: addr 0x104, rfReadAddr=2.
  - Then done pulses once with wbAddr=0x108 and busy falls.
- Load, regList=15'h4001, base=0x200, memReadData 0xAA then 0xBB.
  - rfWriteEn pulses write R0=0xAA, then R14=0xBB (the second in the DONE cycle).
  - Register-file readback confirms both values.
- memReady stalls: load of R3 with memReady low for 3 cycles.
  - memAddr and memReadEn are held stable and no rfWriteEn occurs.
  - The write happens only in the cycle after memReady=1.
- Empty list: start with regList=0 and base=0x40.
  - Next cycle done=1 with wbAddr=0x40.
  - No memReadEn, memWriteEn or rfWriteEn is ever asserted.
- Mid-transfer: rst asserted during the 2nd access of a 4-register load.
  - Next cycle: all outputs 0, state IDLE, no further rfWriteEn.
- Same run, second half: start asserted while busy.
  - start is ignored; the mask is unchanged and there is no extra done.
- Wrap-around: store of R1,R2 at base 0xFFFFFFFC.
  - Addresses 0xFFFFFFFC then 0x00000000; wbAddr=0x4.
